// File: rtl/inst_rom_responder.sv
// Instruction-memory responder for the CPU fetch path: registered word return after
// WAIT_CYCLES wait states, plus a big-endian byte-stream loader for filling the array.
module inst_rom_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned INST_LENGTH = 32,
    parameter int unsigned PC_LENGTH   = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   romCe,
    input  logic [PC_LENGTH-1:0]   pc,
    output logic [INST_LENGTH-1:0] inst,
    output logic                   instValid,
    output logic                   addrErr,
    input  logic                   ldStart,
    input  logic                   ldValid,
    input  logic [7:0]             ldData,
    output logic                   ldReady,
    input  logic                   ldEnd,
    output logic [ADDR_WIDTH:0]    ldWords,
    output logic                   ldOvf
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORDS_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD} state_e;

    state_e                 state_q, state_d;
    logic [PC_LENGTH-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INST_LENGTH-1:0] inst_q, inst_d;
    logic                   inst_valid_q, inst_valid_d;
    logic                   addr_err_q, addr_err_d;
    logic                   ld_ready_q, ld_ready_d;
    logic [WORDS_W-1:0]     ld_words_q, ld_words_d;
    logic                   ld_ovf_q, ld_ovf_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [INST_LENGTH-1:0] word_buf_q, word_buf_d;

    logic [INST_LENGTH-1:0] mem [DEPTH];

    logic [PC_LENGTH-1:0]   fetch_pc_c;
    logic                   fetch_err_c;
    logic [INST_LENGTH-1:0] fetch_word_c;
    logic                   do_wr_c;
    logic [INST_LENGTH-1:0] wr_data_c;
    logic [INST_LENGTH-1:0] pend_buf_c;
    logic [1:0]             pend_cnt_c;
    logic                   mem_we_c;
    logic [ADDR_WIDTH-1:0]  mem_waddr_c;

    // Decode uses the live pc on a zero-wait capture, the latched pc at the end of WAIT.
    assign fetch_pc_c   = (state_q == S_IDLE) ? pc : pc_q;
    assign fetch_err_c  = (fetch_pc_c[1:0] != 2'b00) || ((fetch_pc_c >> (ADDR_WIDTH + 2)) != '0);
    assign fetch_word_c = mem[fetch_pc_c[ADDR_WIDTH+1:2]];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        ld_words_d   = ld_words_q;
        ld_ovf_d     = ld_ovf_q;
        byte_cnt_d   = byte_cnt_q;
        word_buf_d   = word_buf_q;
        do_wr_c      = 1'b0;
        wr_data_c    = word_buf_q;
        pend_buf_c   = word_buf_q;
        pend_cnt_c   = byte_cnt_q;
        mem_we_c     = 1'b0;
        mem_waddr_c  = ld_words_q[ADDR_WIDTH-1:0];

        if (ldStart) begin
            state_d    = S_LOAD;
            cnt_d      = '0;
            ld_words_d = '0;
            ld_ovf_d   = 1'b0;
            byte_cnt_d = '0;
            word_buf_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (romCe) begin
                        pc_d = pc;
                        if (WAIT_CYCLES == 0) begin
                            inst_d       = fetch_err_c ? '0 : fetch_word_c;
                            inst_valid_d = 1'b1;
                            addr_err_d   = fetch_err_c;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                S_WAIT: begin
                    if (!romCe) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_d      = S_IDLE;
                        cnt_d        = '0;
                        inst_d       = fetch_err_c ? '0 : fetch_word_c;
                        inst_valid_d = 1'b1;
                        addr_err_d   = fetch_err_c;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    // Byte is folded in before any same-edge flush so ldEnd sees it.
                    if (ldValid) begin
                        unique case (byte_cnt_q)
                            2'd0: pend_buf_c[INST_LENGTH-1  -: 8] = ldData;
                            2'd1: pend_buf_c[INST_LENGTH-9  -: 8] = ldData;
                            2'd2: pend_buf_c[INST_LENGTH-17 -: 8] = ldData;
                            default: pend_buf_c[INST_LENGTH-25 -: 8] = ldData;
                        endcase
                        if (byte_cnt_q == 2'd3) begin
                            do_wr_c    = 1'b1;
                            wr_data_c  = pend_buf_c;
                            pend_buf_c = '0;
                        end
                        pend_cnt_c = byte_cnt_q + 2'd1;
                    end
                    if (ldEnd) begin
                        if (pend_cnt_c != 2'd0) begin
                            do_wr_c   = 1'b1;
                            wr_data_c = pend_buf_c;
                        end
                        pend_buf_c = '0;
                        pend_cnt_c = '0;
                        state_d    = S_IDLE;
                    end
                    word_buf_d = pend_buf_c;
                    byte_cnt_d = pend_cnt_c;
                    // Pointer saturates at DEPTH; writes beyond it are dropped and flagged.
                    if (do_wr_c) begin
                        if (ld_words_q == WORDS_W'(DEPTH)) begin
                            ld_ovf_d = 1'b1;
                        end else begin
                            mem_we_c   = 1'b1;
                            ld_words_d = ld_words_q + WORDS_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        ld_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            ld_ready_q   <= 1'b0;
            ld_words_q   <= '0;
            ld_ovf_q     <= 1'b0;
            byte_cnt_q   <= '0;
            word_buf_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            addr_err_q   <= addr_err_d;
            ld_ready_q   <= ld_ready_d;
            ld_words_q   <= ld_words_d;
            ld_ovf_q     <= ld_ovf_d;
            byte_cnt_q   <= byte_cnt_d;
            word_buf_q   <= word_buf_d;
        end
    end

    // Storage is deliberately not reset so loaded code survives a core reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= wr_data_c;
        end
    end

    assign inst      = inst_q;
    assign instValid = inst_valid_q;
    assign addrErr   = addr_err_q;
    assign ldReady   = ld_ready_q;
    assign ldWords   = ld_words_q;
    assign ldOvf     = ld_ovf_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench: three responders share stimulus (W=0 depth 1024, W=3 depth 1024, W=0 depth 4).
module tb_inst_rom_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        romCe = 1'b0;
    logic [31:0] pc = '0;
    logic        ldStart = 1'b0;
    logic        ldValid = 1'b0;
    logic [7:0]  ldData = '0;
    logic        ldEnd = 1'b0;

    logic [31:0] inst0, inst3, inst2;
    logic        iv0, iv3, iv2;
    logic        ae0, ae3, ae2;
    logic        rdy0, rdy3, rdy2;
    logic [10:0] words0, words3;
    logic [2:0]  words2;
    logic        ovf0, ovf3, ovf2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_rom_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .romCe(romCe), .pc(pc), .inst(inst0), .instValid(iv0),
        .addrErr(ae0), .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldReady(rdy0), .ldEnd(ldEnd), .ldWords(words0), .ldOvf(ovf0));

    inst_rom_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .romCe(romCe), .pc(pc), .inst(inst3), .instValid(iv3),
        .addrErr(ae3), .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldReady(rdy3), .ldEnd(ldEnd), .ldWords(words3), .ldOvf(ovf3));

    inst_rom_responder #(.ADDR_WIDTH(2), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .rst(rst), .romCe(romCe), .pc(pc), .inst(inst2), .instValid(iv2),
        .addrErr(ae2), .ldStart(ldStart), .ldValid(ldValid), .ldData(ldData),
        .ldReady(rdy2), .ldEnd(ldEnd), .ldWords(words2), .ldOvf(ovf2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ldValid = 1'b1;
        ldData  = b;
        step();
        ldValid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_chk++; if (inst0 !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want %h", inst0, 32'h0); end
        n_chk++; if ({iv0, ae0, rdy0, ovf0} !== 4'b0) begin n_fail++; $display("FAIL reset_flags0: got %b want %b", {iv0, ae0, rdy0, ovf0}, 4'b0); end
        n_chk++; if (words0 !== 11'd0) begin n_fail++; $display("FAIL reset_words0: got %0d want 0", words0); end
        n_chk++; if ({iv3, ae3, rdy3, ovf3, iv2, ae2, rdy2, ovf2} !== 8'b0) begin n_fail++; $display("FAIL reset_flags32: got %b want %b", {iv3, ae3, rdy3, ovf3, iv2, ae2, rdy2, ovf2}, 8'b0); end
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_fetch();
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL lf_ready: got %b want 1", rdy0); end
        send_byte(8'h34); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        ldEnd = 1'b1;
        step();
        ldEnd = 1'b0;
        n_chk++; if (words0 !== 11'd2) begin n_fail++; $display("FAIL lf_words: got %0d want 2", words0); end
        n_chk++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL lf_ready_off: got %b want 0", rdy0); end
        romCe = 1'b1;
        pc    = 32'h0;
        step();
        romCe = 1'b0;
        n_chk++; if (inst0 !== 32'h34010005) begin n_fail++; $display("FAIL lf_inst: got %h want %h", inst0, 32'h34010005); end
        n_chk++; if ({iv0, ae0} !== 2'b10) begin n_fail++; $display("FAIL lf_valid: got %b want %b", {iv0, ae0}, 2'b10); end
        step();
        n_chk++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL lf_pulse: got %b want 0", iv0); end
        n_chk++; if (inst0 !== 32'h34010005) begin n_fail++; $display("FAIL lf_hold: got %h want %h", inst0, 32'h34010005); end
    endtask

    task automatic test_back_to_back();
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        send_byte(8'h99); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        ldEnd = 1'b1;
        step();
        ldEnd = 1'b0;
        n_chk++; if (words0 !== 11'd3) begin n_fail++; $display("FAIL b2b_words: got %0d want 3", words0); end
        romCe = 1'b1;
        pc = 32'h0;
        step();
        n_chk++; if ({iv0, inst0} !== {1'b1, 32'h11223344}) begin n_fail++; $display("FAIL b2b_w0: got %b %h want 1 %h", iv0, inst0, 32'h11223344); end
        pc = 32'h4;
        step();
        n_chk++; if ({iv0, inst0} !== {1'b1, 32'h55667788}) begin n_fail++; $display("FAIL b2b_w1: got %b %h want 1 %h", iv0, inst0, 32'h55667788); end
        pc = 32'h8;
        step();
        n_chk++; if ({iv0, inst0} !== {1'b1, 32'h99AABBCC}) begin n_fail++; $display("FAIL b2b_w2: got %b %h want 1 %h", iv0, inst0, 32'h99AABBCC); end
        romCe = 1'b0;
        step();
        n_chk++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", iv0); end
    endtask

    task automatic test_wait_states();
        romCe = 1'b1;
        pc = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++; if (iv3 !== 1'b0) begin n_fail++; $display("FAIL ws_early%0d: got %b want 0", i, iv3); end
        end
        step();
        romCe = 1'b0;
        n_chk++; if ({iv3, inst3} !== {1'b1, 32'h55667788}) begin n_fail++; $display("FAIL ws_resp: got %b %h want 1 %h", iv3, inst3, 32'h55667788); end
        step();
        n_chk++; if (iv3 !== 1'b0) begin n_fail++; $display("FAIL ws_pulse: got %b want 0", iv3); end
        romCe = 1'b1;
        pc = 32'h8;
        step();
        step();
        romCe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if ({iv3, inst3} !== {1'b0, 32'h55667788}) begin n_fail++; $display("FAIL ws_abort%0d: got %b %h want 0 %h", i, iv3, inst3, 32'h55667788); end
        end
    endtask

    task automatic test_errors();
        romCe = 1'b1;
        pc = 32'h2;
        step();
        n_chk++; if ({iv0, ae0, inst0} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL err_misalign: got %b%b %h want 11 0", iv0, ae0, inst0); end
        pc = 32'h1000;
        step();
        n_chk++; if ({iv0, ae0, inst0} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL err_range: got %b%b %h want 11 0", iv0, ae0, inst0); end
        pc = 32'h4;
        step();
        n_chk++; if ({iv0, ae0, inst0} !== {2'b10, 32'h55667788}) begin n_fail++; $display("FAIL err_recover: got %b%b %h want 10 %h", iv0, ae0, inst0, 32'h55667788); end
        romCe = 1'b0;
        step();
        n_chk++; if ({iv0, ae0} !== 2'b00) begin n_fail++; $display("FAIL err_pulse: got %b want 00", {iv0, ae0}); end
    endtask

    task automatic test_overflow();
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        n_chk++; if ({words2, ovf2} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL ovf_full: got %0d %b want 4 0", words2, ovf2); end
        ldValid = 1'b1;
        ldData  = 8'hAB;
        ldEnd   = 1'b1;
        step();
        ldValid = 1'b0;
        ldEnd   = 1'b0;
        n_chk++; if ({words2, ovf2, rdy2} !== {3'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ovf_flag: got %0d %b %b want 4 1 0", words2, ovf2, rdy2); end
        n_chk++; if ({words0, ovf0} !== {11'd5, 1'b0}) begin n_fail++; $display("FAIL ovf_deep: got %0d %b want 5 0", words0, ovf0); end
        romCe = 1'b1;
        pc = 32'hC;
        step();
        n_chk++; if ({iv2, ae2, inst2} !== {2'b10, 32'h0D0E0F10}) begin n_fail++; $display("FAIL ovf_w3: got %b%b %h want 10 %h", iv2, ae2, inst2, 32'h0D0E0F10); end
        pc = 32'h10;
        step();
        n_chk++; if ({iv2, ae2, inst2} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL ovf_range: got %b%b %h want 11 0", iv2, ae2, inst2); end
        n_chk++; if ({iv0, ae0, inst0} !== {2'b10, 32'hAB000000}) begin n_fail++; $display("FAIL ovf_pad: got %b%b %h want 10 %h", iv0, ae0, inst0, 32'hAB000000); end
        romCe = 1'b0;
        step();
    endtask

    task automatic test_priority();
        romCe = 1'b1;
        pc = 32'h0;
        step();
        ldStart = 1'b1;
        ldEnd   = 1'b1;
        step();
        ldStart = 1'b0;
        ldEnd   = 1'b0;
        romCe   = 1'b0;
        n_chk++; if ({iv3, rdy3} !== 2'b01) begin n_fail++; $display("FAIL pri_abort: got %b want 01", {iv3, rdy3}); end
        n_chk++; if ({words2, ovf2, rdy0} !== {3'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL pri_clear: got %0d %b %b want 0 0 1", words2, ovf2, rdy0); end
        step();
        n_chk++; if (iv3 !== 1'b0) begin n_fail++; $display("FAIL pri_late: got %b want 0", iv3); end
        send_byte(8'hDE);
        send_byte(8'hAD);
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        ldEnd = 1'b1;
        step();
        ldEnd = 1'b0;
        n_chk++; if ({words0, rdy0} !== {11'd0, 1'b0}) begin n_fail++; $display("FAIL pri_restart: got %0d %b want 0 0", words0, rdy0); end
        ldStart = 1'b1;
        step();
        ldStart = 1'b0;
        send_byte(8'h77);
        #2 rst = 1'b0;
        #1;
        n_chk++; if ({rdy0, iv0, ae0, ovf0, words0, inst0} !== '0) begin n_fail++; $display("FAIL pri_rst: got %b%b%b%b %0d %h want all 0", rdy0, iv0, ae0, ovf0, words0, inst0); end
        #2 rst = 1'b1;
        step();
        romCe = 1'b1;
        pc = 32'hC;
        step();
        n_chk++; if ({iv0, inst0} !== {1'b1, 32'h0D0E0F10}) begin n_fail++; $display("FAIL pri_keep3: got %b %h want 1 %h", iv0, inst0, 32'h0D0E0F10); end
        pc = 32'h0;
        step();
        n_chk++; if ({iv0, inst0} !== {1'b1, 32'h01020304}) begin n_fail++; $display("FAIL pri_keep0: got %b %h want 1 %h", iv0, inst0, 32'h01020304); end
        romCe = 1'b0;
        step();
        n_chk++; if (iv0 !== 1'b0) begin n_fail++; $display("FAIL pri_idle: got %b want 0", iv0); end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_overflow();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
